wb_cmd_master: RTL and testbench
================================

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning wb_clk_i cycles to wait for ack/err before abort (range 1..65535).
REQ-002 SHALL have port wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port wb_rst_i  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port cmd_valid_i  in  1  command offered.
REQ-005 SHALL have port cmd_ready_o  out  1  command accepted when cmd_valid_i & cmd_ready_o.
REQ-006 SHALL have ports cmd_we_i in 1, cmd_adr_i in 32, cmd_dat_i in 32, cmd_sel_i in 4: write flag, address, write data, byte selects.
REQ-007 SHALL have port rsp_valid_o  out  1  response available.
REQ-008 SHALL have port rsp_ready_i  in  1  response consumed when rsp_valid_o & rsp_ready_i.
REQ-009 SHALL have ports rsp_dat_o out 32 (read data) and rsp_status_o out 2 (00 ok, 01 bus error, 10 timeout, 11 unused).
REQ-010 SHALL have Wishbone initiator ports wb_cyc_o, wb_stb_o, wb_we_o out 1; wb_adr_o out 32; wb_dat_o out 32; wb_sel_o out 4; wb_dat_i in 32; wb_ack_i in 1; wb_err_i in 1.
REQ-011 SHALL have port busy_o  out  1  high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, BUS, RESP.
REQ-013 IDLE: cmd_ready_o=1; on accept, register we/adr/dat/sel and go BUS; wb_cyc_o/wb_stb_o high from the next cycle.
REQ-014 BUS: cmd_ready_o=0; wb_cyc_o=wb_stb_o=1; wb_we_o/adr/dat/sel hold registered command values stable until termination.
REQ-015 BUS: first cycle sampling wb_ack_i or wb_err_i high terminates; wb_cyc_o/wb_stb_o low on the following cycle; go RESP.
REQ-016 ack and err in the same cycle SHALL be treated as error (status 01).
REQ-017 On ack of a read, rsp_dat_o SHALL capture wb_dat_i in that cycle; for writes, errors and timeouts rsp_dat_o SHALL be 0.
REQ-018 RESP: rsp_valid_o=1 with rsp_dat_o/rsp_status_o stable until rsp_ready_i; on handshake go IDLE (cmd_ready_o=1 next cycle).
REQ-019 Latency: accept at cycle N -> wb_stb_o at N+1; ack at cycle M -> rsp_valid_o at M+1; rsp_ready_i held high -> next accept at M+2.
REQ-020 wb_ack_i/wb_err_i while not in BUS SHALL be ignored.
REQ-021 cmd_* inputs SHALL be ignored while cmd_ready_o=0; exactly one outstanding transaction.
REQ-022 wb_we_o SHALL be 0 and wb_adr_o/wb_dat_o/wb_sel_o SHALL be 0 while wb_cyc_o=0.

Reset
REQ-023 wb_rst_i sampled high SHALL force IDLE next cycle with cmd_ready_o=1, rsp_valid_o=0, rsp_dat_o=0, rsp_status_o=00, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=wb_dat_o=0, wb_sel_o=0, busy_o=0, timeout counter=0.
REQ-024 Reset in BUS SHALL drop wb_cyc_o/wb_stb_o next cycle and discard the transaction without producing a response.
REQ-025 Reset in RESP SHALL discard the pending response.

Configuration
REQ-026 Macro WB_CMD_MASTER_TIMEOUT_EN defined: 16-bit counter cleared on BUS entry, incremented each BUS cycle without ack/err; on reaching TIMEOUT_CYCLES the cycle SHALL abort (cyc/stb low next cycle) and go RESP with status 10; ack/err in the same cycle the limit is reached take priority.
REQ-027 Macro undefined: no counter; BUS waits indefinitely; status 10 never produced; TIMEOUT_CYCLES unused.

Verification
REQ-028 Write adr=0x0000_1000 dat=0xDEAD_BEEF sel=0xF, ack after 2 wait cycles -> wb_we_o=1 with those values, rsp_valid_o with status 00, rsp_dat_o=0.
REQ-029 Read adr=0x0000_0004, ack with wb_dat_i=0x1234_5678 -> rsp_dat_o=0x1234_5678, status 00; rsp_ready_i low 3 cycles -> response held stable, cmd_ready_o=0.
REQ-030 Read with wb_ack_i and wb_err_i high together -> status 01, rsp_dat_o=0, cyc/stb low next cycle.
REQ-031 WB_CMD_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> cyc/stb low after 4 BUS cycles, status 10; without macro cyc held 100+ cycles.
REQ-032 wb_rst_i asserted in BUS -> cyc/stb low next cycle, no rsp_valid_o, next command accepted normally.

Source files
------------

// File: rtl/wb_cmd_master_if.sv
// Command/response handshake and Wishbone initiator bundle for wb_cmd_master.
interface wb_cmd_master_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_adr_i;
    logic [31:0] cmd_dat_i;
    logic [3:0]  cmd_sel_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_dat_o;
    logic [1:0]  rsp_status_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_status_o,
        input  rsp_ready_i,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_status_o,
        output rsp_ready_i,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Single-outstanding command to Wishbone initiator bridge.
// Optional bus timeout enabled by defining WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    output logic             busy_o,
    wb_cmd_master_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_TMO = 2'b10;

    state_t      state_q, state_d;
    logic        we_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [3:0]  sel_q;
    logic [31:0] rsp_dat_q;
    logic [1:0]  rsp_status_q;
    logic        tmo;
    logic        term;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYCLES);
    logic [15:0] cnt_q;

    // Fires in the BUS cycle whose increment would reach the limit.
    assign tmo = (state_q == BUS) && (cnt_q + 16'd1 == TMO_LIM);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
        end else if (state_q != BUS) begin
            cnt_q <= '0;
        end else if (!bus.wb_ack_i && !bus.wb_err_i) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    assign term = bus.wb_ack_i | bus.wb_err_i | tmo;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.cmd_valid_i) state_d = BUS;
            BUS:     if (term) state_d = RESP;
            RESP:    if (bus.rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            rsp_dat_q    <= '0;
            rsp_status_q <= ST_OK;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.cmd_valid_i) begin
                        we_q  <= bus.cmd_we_i;
                        adr_q <= bus.cmd_adr_i;
                        dat_q <= bus.cmd_dat_i;
                        sel_q <= bus.cmd_sel_i;
                    end
                end
                BUS: begin
                    // err wins over ack; either wins over timeout
                    if (bus.wb_err_i) begin
                        rsp_dat_q    <= '0;
                        rsp_status_q <= ST_ERR;
                    end else if (bus.wb_ack_i) begin
                        rsp_dat_q    <= we_q ? 32'd0 : bus.wb_dat_i;
                        rsp_status_q <= ST_OK;
                    end else if (tmo) begin
                        rsp_dat_q    <= '0;
                        rsp_status_q <= ST_TMO;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o           = (state_q != IDLE);
    assign bus.cmd_ready_o  = (state_q == IDLE);
    assign bus.rsp_valid_o  = (state_q == RESP);
    assign bus.rsp_dat_o    = rsp_dat_q;
    assign bus.rsp_status_o = rsp_status_q;
    assign bus.wb_cyc_o     = (state_q == BUS);
    assign bus.wb_stb_o     = (state_q == BUS);
    assign bus.wb_we_o      = (state_q == BUS) ? we_q  : 1'b0;
    assign bus.wb_adr_o     = (state_q == BUS) ? adr_q : 32'd0;
    assign bus.wb_dat_o     = (state_q == BUS) ? dat_q : 32'd0;
    assign bus.wb_sel_o     = (state_q == BUS) ? sel_q : 4'd0;
endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed self-checking bench for wb_cmd_master.
// Timeout path exercised when WB_CMD_MASTER_TIMEOUT_EN is defined.
module tb_wb_cmd_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   total = 0;
    int   bad = 0;
    int   n;

    wb_cmd_master_if bus ();

    wb_cmd_master #(.TIMEOUT_CYCLES(4)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .busy_o   (busy),
        .bus      (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic offer(input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = we;
        bus.cmd_adr_i   = adr;
        bus.cmd_dat_i   = dat;
        bus.cmd_sel_i   = sel;
        step();
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'b1;
        bus.cmd_adr_i   = 32'hFFFF_FFFF;
        bus.cmd_dat_i   = 32'hFFFF_FFFF;
        bus.cmd_sel_i   = 4'hA;
    endtask

    initial begin
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_adr_i   = '0;
        bus.cmd_dat_i   = '0;
        bus.cmd_sel_i   = '0;
        bus.rsp_ready_i = 1'b1;
        bus.wb_dat_i    = '0;
        bus.wb_ack_i    = 1'b0;
        bus.wb_err_i    = 1'b0;

        step();
        step();
        rst = 1'b0;
        chk("rst_cmd_ready", 32'(bus.cmd_ready_o), 1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 0);
        chk("rst_cyc", 32'(bus.wb_cyc_o), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_adr", bus.wb_adr_o, 0);
        chk("rst_sel", 32'(bus.wb_sel_o), 0);
        chk("rst_rsp_dat", bus.rsp_dat_o, 0);
        chk("rst_status", 32'(bus.rsp_status_o), 0);

        // ack while idle must be ignored
        bus.wb_ack_i = 1'b1;
        step();
        bus.wb_ack_i = 1'b0;
        chk("idle_ack_rsp", 32'(bus.rsp_valid_o), 0);
        chk("idle_ack_cyc", 32'(bus.wb_cyc_o), 0);

        // write, ack after 2 wait cycles
        offer(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
        chk("wr_cyc", 32'(bus.wb_cyc_o), 1);
        chk("wr_stb", 32'(bus.wb_stb_o), 1);
        chk("wr_we", 32'(bus.wb_we_o), 1);
        chk("wr_adr", bus.wb_adr_o, 32'h0000_1000);
        chk("wr_dat", bus.wb_dat_o, 32'hDEAD_BEEF);
        chk("wr_sel", 32'(bus.wb_sel_o), 32'hF);
        chk("wr_cmd_ready", 32'(bus.cmd_ready_o), 0);
        chk("wr_busy", 32'(busy), 1);
        step();
        chk("wr_wait2_cyc", 32'(bus.wb_cyc_o), 1);
        chk("wr_wait2_adr", bus.wb_adr_o, 32'h0000_1000);
        step();
        bus.wb_ack_i = 1'b1;
        step();
        bus.wb_ack_i = 1'b0;
        chk("wr_end_cyc", 32'(bus.wb_cyc_o), 0);
        chk("wr_end_we", 32'(bus.wb_we_o), 0);
        chk("wr_end_adr", bus.wb_adr_o, 0);
        chk("wr_rsp_valid", 32'(bus.rsp_valid_o), 1);
        chk("wr_rsp_status", 32'(bus.rsp_status_o), 0);
        chk("wr_rsp_dat", bus.rsp_dat_o, 0);
        step();
        chk("wr_next_ready", 32'(bus.cmd_ready_o), 1);
        chk("wr_next_rspv", 32'(bus.rsp_valid_o), 0);

        // read, response back-pressured 3 cycles
        bus.rsp_ready_i = 1'b0;
        offer(1'b0, 32'h0000_0004, 32'h5555_5555, 4'hF);
        chk("rd_we", 32'(bus.wb_we_o), 0);
        chk("rd_adr", bus.wb_adr_o, 32'h0000_0004);
        bus.wb_ack_i = 1'b1;
        bus.wb_dat_i = 32'h1234_5678;
        step();
        bus.wb_ack_i = 1'b0;
        bus.wb_dat_i = 32'hCAFE_F00D;
        chk("rd_cyc_low", 32'(bus.wb_cyc_o), 0);
        for (int i = 0; i < 3; i++) begin
            chk("rd_hold_valid", 32'(bus.rsp_valid_o), 1);
            chk("rd_hold_dat", bus.rsp_dat_o, 32'h1234_5678);
            chk("rd_hold_status", 32'(bus.rsp_status_o), 0);
            chk("rd_hold_ready", 32'(bus.cmd_ready_o), 0);
            bus.cmd_valid_i = 1'b1;
            bus.wb_err_i    = (i == 1);
            step();
        end
        bus.cmd_valid_i = 1'b0;
        bus.wb_err_i    = 1'b0;
        chk("rd_still_dat", bus.rsp_dat_o, 32'h1234_5678);
        chk("rd_still_cyc", 32'(bus.wb_cyc_o), 0);
        bus.rsp_ready_i = 1'b1;
        step();
        chk("rd_done_ready", 32'(bus.cmd_ready_o), 1);
        chk("rd_done_rspv", 32'(bus.rsp_valid_o), 0);

        // ack and err together is an error
        offer(1'b0, 32'h0000_0008, 32'h0, 4'h3);
        bus.wb_ack_i = 1'b1;
        bus.wb_err_i = 1'b1;
        bus.wb_dat_i = 32'hFFFF_0000;
        step();
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
        chk("ae_cyc", 32'(bus.wb_cyc_o), 0);
        chk("ae_stb", 32'(bus.wb_stb_o), 0);
        chk("ae_status", 32'(bus.rsp_status_o), 1);
        chk("ae_dat", bus.rsp_dat_o, 0);
        chk("ae_valid", 32'(bus.rsp_valid_o), 1);
        step();

`ifdef WB_CMD_MASTER_TIMEOUT_EN
        offer(1'b0, 32'h0000_000C, 32'h0, 4'hF);
        bus.wb_dat_i = 32'h7777_7777;
        n = 0;
        while (bus.wb_cyc_o && n < 20) begin
            n++;
            step();
        end
        chk("tmo_bus_cycles", n, 4);
        chk("tmo_stb", 32'(bus.wb_stb_o), 0);
        chk("tmo_status", 32'(bus.rsp_status_o), 2);
        chk("tmo_dat", bus.rsp_dat_o, 0);
        chk("tmo_valid", 32'(bus.rsp_valid_o), 1);
        step();
        chk("tmo_idle", 32'(bus.cmd_ready_o), 1);
`else
        offer(1'b0, 32'h0000_000C, 32'h0, 4'hF);
        n = 0;
        for (int i = 0; i < 110; i++) begin
            if (bus.wb_cyc_o) n++;
            step();
        end
        chk("notmo_held", n, 110);
        chk("notmo_rspv", 32'(bus.rsp_valid_o), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("notmo_rst_cyc", 32'(bus.wb_cyc_o), 0);
`endif

        // reset while in BUS discards the transaction
        offer(1'b1, 32'h0000_2000, 32'h0BAD_F00D, 4'h1);
        chk("rb_cyc_pre", 32'(bus.wb_cyc_o), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rb_cyc", 32'(bus.wb_cyc_o), 0);
        chk("rb_stb", 32'(bus.wb_stb_o), 0);
        chk("rb_busy", 32'(busy), 0);
        chk("rb_ready", 32'(bus.cmd_ready_o), 1);
        chk("rb_status", 32'(bus.rsp_status_o), 0);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.rsp_valid_o) n++;
            step();
        end
        chk("rb_no_rsp", n, 0);
        offer(1'b0, 32'h0000_0010, 32'h0, 4'hC);
        chk("rb_next_adr", bus.wb_adr_o, 32'h0000_0010);
        chk("rb_next_sel", 32'(bus.wb_sel_o), 32'hC);
        bus.wb_ack_i = 1'b1;
        bus.wb_dat_i = 32'hAA55_AA55;
        step();
        bus.wb_ack_i = 1'b0;
        chk("rb_next_dat", bus.rsp_dat_o, 32'hAA55_AA55);
        chk("rb_next_status", 32'(bus.rsp_status_o), 0);
        chk("rb_next_valid", 32'(bus.rsp_valid_o), 1);

        // reset while in RESP discards the response
        bus.rsp_ready_i = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rr_valid", 32'(bus.rsp_valid_o), 0);
        chk("rr_dat", bus.rsp_dat_o, 0);
        chk("rr_ready", 32'(bus.cmd_ready_o), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
